// File: rtl/conv_pkg.sv
// Shared types, kernel weights and the clamp helper for the
// 3x3 convolution engine.
package conv_pkg;

  localparam int KSIZE     = 3;
  localparam int WIDTH_BIT = 8;
  localparam int ACC_W     =
    2 * WIDTH_BIT + $clog2(KSIZE * KSIZE) + 1;
  localparam int PIX_MAX   = (1 << WIDTH_BIT) - 1;

  typedef logic        [WIDTH_BIT-1:0] pixel_t;
  typedef logic signed [WIDTH_BIT-1:0] weight_t;
  typedef logic signed [ACC_W-1:0]     acc_t;

  localparam weight_t WN = -8'sd1;
  localparam weight_t WC = 8'sd8;

  // Laplacian edge kernel
  localparam weight_t KERNEL [KSIZE][KSIZE] = '{
    '{WN, WN, WN},
    '{WN, WC, WN},
    '{WN, WN, WN}
  };

  function automatic pixel_t clamp_pixel(
    input acc_t s
  );
    if (s < 0)
      return '0;
    else if (s > acc_t'(PIX_MAX))
      return pixel_t'(PIX_MAX);
    else
      return s[WIDTH_BIT-1:0];
  endfunction

endpackage

// File: rtl/conv_window_mac_index.sv
// Raster (row, col) generator for the sliding window;
// advances one position per ena cycle.
module window_index_gen #(
  parameter int OUT_SIZE  = 5,
  parameter int WIDTH_BIT = 8
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 ena,
  output logic [WIDTH_BIT-1:0] row_idx,
  output logic [WIDTH_BIT-1:0] col_idx
);

  localparam logic [WIDTH_BIT-1:0] LAST =
    WIDTH_BIT'(OUT_SIZE - 1);

  logic [WIDTH_BIT-1:0] row_q, row_d;
  logic [WIDTH_BIT-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (ena) begin
      if (col_q < LAST) begin
        col_d = col_q + 1'b1;
      end else begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_idx = row_q;
  assign col_idx = col_q;

endmodule

// File: rtl/conv_window_mac.sv
// KSIZE x KSIZE window MAC against a fixed signed kernel,
// clamped to a pixel and registered, plus the window index.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int OUT_SIZE = 5
) (
  input  logic                               clock,
  input  logic                               nreset,
  input  logic [KSIZE*KSIZE*WIDTH_BIT-1:0]   win,
  input  logic                               ena,
  output logic [WIDTH_BIT-1:0]               conv_out,
  output logic [WIDTH_BIT-1:0]               row_idx,
  output logic [WIDTH_BIT-1:0]               col_idx
);

  acc_t   acc;
  acc_t   px;
  acc_t   wt;
  pixel_t conv_q, conv_d;

  // Pixels are zero-extended, weights sign-extended.
  always_comb begin
    acc = '0;
    px  = '0;
    wt  = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        px  = acc_t'(win[(r*KSIZE+c)*WIDTH_BIT +: WIDTH_BIT]);
        wt  = acc_t'(KERNEL[r][c]);
        acc = acc + px * wt;
      end
    end
  end

  always_comb begin
    conv_d = conv_q;
    if (!ena)
      conv_d = clamp_pixel(acc);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)
      conv_q <= '0;
    else
      conv_q <= conv_d;
  end

  assign conv_out = conv_q;

  window_index_gen #(
    .OUT_SIZE  (OUT_SIZE),
    .WIDTH_BIT (WIDTH_BIT)
  ) u_idx (
    .clock   (clock),
    .nreset  (nreset),
    .ena     (ena),
    .row_idx (row_idx),
    .col_idx (col_idx)
  );

endmodule

// File: tb/tb_conv_window_mac.sv
// Self-checking bench for conv_window_mac: reference model
// plus directed vectors with hand-computed expectations.
module tb_conv_window_mac;

  localparam int K  = 3;
  localparam int W  = 8;
  localparam int OS = 5;

  logic             clock;
  logic             nreset;
  logic [K*K*W-1:0] win;
  logic             ena;
  logic [W-1:0]     conv_out;
  logic [W-1:0]     row_idx;
  logic [W-1:0]     col_idx;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 0;

  int m_conv;
  int m_pos;

  int stored [OS][OS];

  conv_window_mac #(.OUT_SIZE(OS)) dut (
    .clock    (clock),
    .nreset   (nreset),
    .win      (win),
    .ena      (ena),
    .conv_out (conv_out),
    .row_idx  (row_idx),
    .col_idx  (col_idx)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic check(input string name,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d",
               name, act, exp);
    end
  endtask

  // Laplacian: centre +8, every neighbour -1, clamp to 0..255.
  function automatic int model_conv(
    input logic [K*K*W-1:0] w
  );
    int s = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        int p = int'(w[(r*K+c)*W +: W]);
        s += (r == 1 && c == 1) ? 8 * p : -p;
      end
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      m_conv <= 0;
      m_pos  <= 0;
    end else if (!ena) begin
      m_conv <= model_conv(win);
    end else begin
      m_pos <= (m_pos + 1) % (OS * OS);
    end
  end

  always @(negedge clock) begin
    if (cmp_on && nreset) begin
      check("model_conv", int'(conv_out), m_conv);
      check("model_row", int'(row_idx), m_pos / OS);
      check("model_col", int'(col_idx), m_pos % OS);
    end
  end

  task automatic set_win(input int ctr, input int nb);
    for (int i = 0; i < K * K; i++)
      win[i*W +: W] = W'(nb);
    win[4*W +: W] = W'(ctr);
  endtask

  // Inputs change at negedge+1; outputs checked the next negedge+1.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic idx_is(input string n,
                        input int r, input int c);
    check({n, "_row"}, int'(row_idx), r);
    check({n, "_col"}, int'(col_idx), c);
  endtask

  initial begin
    nreset = 0;
    ena    = 0;
    win    = '0;
    #12;
    check("reset_conv", int'(conv_out), 0);
    idx_is("reset", 0, 0);
    nreset = 1;
    cmp_on = 1;

    set_win(50, 0);  cyc();
    check("sat_hi", int'(conv_out), 255);
    set_win(10, 10); cyc();
    check("uniform", int'(conv_out), 0);
    set_win(10, 1);  cyc();
    check("pos72", int'(conv_out), 72);

    ena = 1;
    set_win(50, 0);
    repeat (3) cyc();
    check("hold_conv", int'(conv_out), 72);
    idx_is("hold", 0, 3);

    ena = 0;
    set_win(0, 20);   cyc();
    check("neg_clamp", int'(conv_out), 0);
    set_win(10, 1);   cyc();
    check("pos72b", int'(conv_out), 72);
    set_win(255, 255); cyc();
    check("all255", int'(conv_out), 0);

    // Asynchronous reset between edges, state nonzero.
    set_win(10, 1); cyc();
    ena = 1; cyc();
    ena = 0;
    check("pre_rst_conv", int'(conv_out), 72);
    #1 nreset = 0;
    #1;
    check("rst_conv", int'(conv_out), 0);
    idx_is("rst", 0, 0);
    ena = 1; cyc();
    ena = 0; cyc();
    check("rst_hold_conv", int'(conv_out), 0);
    idx_is("rst_hold", 0, 0);
    nreset = 1;
    set_win(0, 0);

    for (int p = 1; p <= OS * OS; p++) begin
      ena = 1; cyc();
      ena = 0; cyc();
      if (p == 5)  idx_is("raster5", 1, 0);
      if (p == 24) idx_is("raster24", 4, 4);
      if (p == 25) idx_is("raster25", 0, 0);
    end

    // 3-state protocol over a 7x7 ramp, pixel = 7*r + c.
    for (int i = 0; i < OS; i++)
      for (int j = 0; j < OS; j++) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            win[(r*K+c)*W +: W] = W'(7*(i+r) + (j+c));
        ena = 0; cyc();
        ena = 0; cyc();
        idx_is("proto_idx", i, j);
        stored[row_idx][col_idx] = int'(conv_out);
        ena = 1; cyc();
      end
    ena = 0;
    for (int i = 0; i < OS; i++)
      for (int j = 0; j < OS; j++)
        check("ramp_out", stored[i][j], 0);
    idx_is("proto_end", 0, 0);

    cmp_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
